uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter CLK_FRE, default 200, meaning system clock frequency in MHz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, meaning serial bit rate in bit/s.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, meaning receive buffer depth in bytes (power of two).
REQ-004 The block SHALL have port sys_clk, input, 1 bit: clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port rx_pin, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The block SHALL have port rx_data, output, 8 bits: head-of-FIFO byte.
REQ-008 The block SHALL have port rx_data_valid, output, 1 bit: FIFO non-empty; rx_data is meaningful.
REQ-009 The block SHALL have port rx_data_ready, input, 1 bit: consumer accepts the head byte.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 The block SHALL have port overflow, output, 1 bit: one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-012 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: bytes currently held.

Function
REQ-013 rx_pin SHALL pass through a 2-flop synchronizer, both flops reset to 1; all decisions use the synchronized value.
REQ-014 Bit period BIT_CYC SHALL be CLK_FRE*1000000/BAUD_RATE, integer-truncated (1736 at defaults); one 32-bit down/up counter times all sampling.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH; reset state IDLE.
REQ-016 IDLE -> START on a synchronized high-to-low transition; bit counter cleared.
REQ-017 In START, at BIT_CYC/2 cycles the line SHALL be sampled: low -> DATA with counter restarted; high -> false start, back to IDLE, no error flagged.
REQ-018 In DATA, 8 bits SHALL be sampled LSB first, each exactly BIT_CYC cycles after the previous sample, into a shift register; after bit 7 -> STOP.
REQ-019 In STOP, the line SHALL be sampled BIT_CYC cycles after bit 7: high -> byte pushed to FIFO, -> IDLE; low -> frame_err pulse, byte discarded, -> WAIT_HIGH.
REQ-020 WAIT_HIGH SHALL -> IDLE only when the synchronized line is high; no start detection while in WAIT_HIGH.
REQ-021 The FIFO SHALL be first-word-fall-through: rx_data_valid = (fifo_count != 0); rx_data shows the oldest byte.
REQ-022 Pop SHALL occur on a cycle with rx_data_valid && rx_data_ready; rx_data and rx_data_valid update on the next edge.
REQ-023 A pushed byte into an empty FIFO SHALL appear on rx_data with rx_data_valid high on the edge after the stop-bit sample (latency 1 cycle).
REQ-024 Push when full with no simultaneous pop: byte dropped, FIFO unchanged, overflow pulses for one cycle.
REQ-025 Push when full with simultaneous pop: both performed, fifo_count stays FIFO_DEPTH, no overflow.
REQ-026 Push and pop in the same cycle otherwise: fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-027 rx_data_ready high while empty SHALL have no effect.
REQ-028 frame_err and overflow SHALL never both be asserted for the same received byte.

Reset
REQ-029 On rst_n low, regardless of state: FSM -> IDLE, FIFO emptied, pointers 0, rx_data=0, rx_data_valid=0, frame_err=0, overflow=0, fifo_count=0, synchronizer=1.
REQ-030 A frame in progress at reset SHALL be abandoned; after release, reception SHALL restart at the next falling edge.

Verification
REQ-031 Send 0x46 at 115200 baud, ready=1 -> rx_data=0x46, rx_data_valid high 1 cycle after stop sample, fifo_count 1 -> 0 after pop.
REQ-032 Drive rx_pin low for 500 cycles then high -> no push, no frame_err, FSM back to IDLE.
REQ-033 Send 0x55 with stop bit=0 -> frame_err single-cycle pulse, fifo_count unchanged, next valid byte 0xA3 received correctly.
REQ-034 ready=0, send 17 bytes 0x00..0x10 -> fifo_count=16, one overflow pulse on the 17th byte, drained order 0x00..0x0F.
REQ-035 Assert rst_n mid-byte (during DATA bit 3) -> all outputs 0; the following 0x7E frame is received as 0x7E.
REQ-036 Back-to-back "FPGA STLINV\r\n" (13 bytes, no idle gap), ready=1 -> 13 bytes out in order, no frame_err, no overflow.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through receive FIFO.
// Ports: sys_clk/rst_n (async active-low) clock and reset; rx_pin serial input (idle high);
//        rx_data/rx_data_valid/rx_data_ready FIFO head handshake; frame_err/overflow
//        one-cycle error pulses; fifo_count holds the number of bytes buffered.
module uart_rx_fifo #(
   parameter int CLK_FRE    = 200,     // system clock in MHz
   parameter int BAUD_RATE  = 115200,  // serial bit rate in bit/s
   parameter int FIFO_DEPTH = 16       // receive buffer depth, power of two
) (
   input  logic                          sys_clk,
   input  logic                          rst_n,
   input  logic                          rx_pin,
   output logic [7:0]                    rx_data,
   output logic                          rx_data_valid,
   input  logic                          rx_data_ready,
   output logic                          frame_err,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam int          CW       = AW + 1;
   localparam logic [31:0] BIT_CYC  = 32'(CLK_FRE * 1000000 / BAUD_RATE);
   localparam logic [31:0] HALF_CYC = BIT_CYC / 32'd2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t      state, state_nxt;
   logic        rx_meta, rx_sync, rx_prev;
   logic [31:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift_reg;

   logic        cnt_clr;
   logic        shift_en;
   logic        push;
   logic        stop_bad;
   logic        half_hit;
   logic        bit_hit;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          pop;
   logic          full;
   logic          wr_en;

   // Synchronizer plus one extra stage used only for falling-edge detection.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx_pin;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign half_hit = (cnt == HALF_CYC - 32'd1);
   assign bit_hit  = (cnt == BIT_CYC - 32'd1);

   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      shift_en  = 1'b0;
      push      = 1'b0;
      stop_bad  = 1'b0;
      case (state)
         IDLE: begin
            if (rx_prev && !rx_sync) begin
               state_nxt = START;
               cnt_clr   = 1'b1;
            end
         end
         START: begin
            // Mid-start-bit check filters glitches shorter than half a bit.
            if (half_hit) begin
               cnt_clr   = 1'b1;
               state_nxt = rx_sync ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_hit) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               if (bit_idx == 3'd7) begin
                  state_nxt = STOP;
               end
            end
         end
         STOP: begin
            if (bit_hit) begin
               cnt_clr = 1'b1;
               if (rx_sync) begin
                  push      = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  stop_bad  = 1'b1;
                  state_nxt = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            // A low line here is still the broken frame, never a new start bit.
            if (rx_sync) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= 32'd0;
         bit_idx   <= 3'd0;
         shift_reg <= 8'h00;
      end else begin
         if (cnt_clr || state == IDLE) begin
            cnt <= 32'd0;
         end else begin
            cnt <= cnt + 32'd1;
         end
         if (state != DATA) begin
            bit_idx <= 3'd0;
         end else if (shift_en) begin
            bit_idx <= bit_idx + 3'd1;
         end
         // LSB arrives first, so shift in from the top.
         if (shift_en) begin
            shift_reg <= {rx_sync, shift_reg[7:1]};
         end
      end
   end

   // Receive FIFO: a push into a full FIFO only succeeds when a pop frees a slot.
   assign rx_data_valid = (fifo_count != '0);
   assign pop           = rx_data_valid && rx_data_ready;
   assign full          = (fifo_count == CW'(FIFO_DEPTH));
   assign wr_en         = push && (!full || pop);
   assign rx_data       = rx_data_valid ? mem[rd_ptr] : 8'h00;

   always_ff @(posedge sys_clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= shift_reg;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
         frame_err <= stop_bad;
         overflow  <= push && full && !pop;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives serial frames into uart_rx_fifo and compares the bytes,
// error pulses and occupancy against a queue-based model of the receiver.
module tb_uart_rx_fifo;

   localparam int CLK_FRE    = 2;
   localparam int BAUD_RATE  = 115200;
   localparam int FIFO_DEPTH = 16;
   localparam int BIT_CYC    = CLK_FRE * 1000000 / BAUD_RATE;
   localparam int HALF       = BIT_CYC / 2;
   localparam int CW         = $clog2(FIFO_DEPTH) + 1;

   logic          sys_clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rx_pin = 1'b1;
   logic [7:0]    rx_data;
   logic          rx_data_valid;
   logic          rx_data_ready = 1'b0;
   logic          frame_err;
   logic          overflow;
   logic [CW-1:0] fifo_count;

   uart_rx_fifo #(
      .CLK_FRE   (CLK_FRE),
      .BAUD_RATE (BAUD_RATE),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .sys_clk      (sys_clk),
      .rst_n        (rst_n),
      .rx_pin       (rx_pin),
      .rx_data      (rx_data),
      .rx_data_valid(rx_data_valid),
      .rx_data_ready(rx_data_ready),
      .frame_err    (frame_err),
      .overflow     (overflow),
      .fifo_count   (fifo_count)
   );

   always #5 sys_clk = ~sys_clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // Consumer side: ready policy, popped-byte log and event counters.
   int         ready_mode = 0;  // 0 never ready, 1 always ready, 2 random
   logic [7:0] got_q[$];
   int         ferr_cnt = 0, ovf_cnt = 0, both_cnt = 0, inv_cnt = 0;
   int         rise_cyc = -1;
   logic       valid_prev = 1'b0;

   always @(negedge sys_clk) begin
      case (ready_mode)
         0:       rx_data_ready = 1'b0;
         1:       rx_data_ready = 1'b1;
         default: rx_data_ready = 1'($urandom_range(0, 1));
      endcase
      if (rst_n) begin
         if (rx_data_valid && rx_data_ready) got_q.push_back(rx_data);
         if (frame_err) ferr_cnt++;
         if (overflow) ovf_cnt++;
         if (frame_err && overflow) both_cnt++;
         if (rx_data_valid != (fifo_count != '0)) inv_cnt++;
         if (rx_data_valid && !valid_prev) rise_cyc = cyc;
      end
      valid_prev = rx_data_valid;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx_pin = 1'b0;
      repeat (BIT_CYC) @(negedge sys_clk);
      for (int i = 0; i < 8; i++) begin
         rx_pin = b[i];
         repeat (BIT_CYC) @(negedge sys_clk);
      end
      rx_pin = stop_bit;
      repeat (BIT_CYC) @(negedge sys_clk);
   endtask

   task automatic idle(input int n);
      rx_pin = 1'b1;
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge sys_clk);
      #1;
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_data"},  32'(rx_data), 32'h0);
      chk({tag, "_valid"}, 32'(rx_data_valid), 32'h0);
      chk({tag, "_ferr"},  32'(frame_err), 32'h0);
      chk({tag, "_ovf"},   32'(overflow), 32'h0);
      chk({tag, "_count"}, 32'(fifo_count), 32'h0);
   endtask

   initial begin
      logic [7:0] exp_q[$];
      string      msg;
      int         base, fb, ob, s_cyc, diff, nbad, gap;
      logic [7:0] b;
      logic       bad;

      // Reset state
      repeat (3) @(negedge sys_clk);
      #1;
      chk_cleared("reset");
      @(posedge sys_clk);
      #1 rst_n = 1'b1;
      wait_cyc(5);

      // Single byte 0x46, held then popped
      base  = got_q.size();
      s_cyc = cyc;
      send_byte(8'h46, 1'b1);
      idle(10);
      wait_cyc(2);
      diff = rise_cyc - s_cyc;
      chk($sformatf("lat46_window(offset=%0d)", diff),
          32'((diff >= HALF + 9 * BIT_CYC + 1) && (diff <= HALF + 9 * BIT_CYC + 4)), 32'd1);
      chk("b46_count", 32'(fifo_count), 32'd1);
      chk("b46_valid", 32'(rx_data_valid), 32'd1);
      chk("b46_data",  32'(rx_data), 32'h46);
      ready_mode = 1;
      wait_cyc(3);
      chk("b46_count_after_pop", 32'(fifo_count), 32'd0);
      chk("b46_pops", 32'(got_q.size() - base), 32'd1);
      if (got_q.size() > base) chk("b46_popped", 32'(got_q[base]), 32'h46);

      // Short low glitch is a false start
      base = got_q.size();
      fb   = ferr_cnt;
      rx_pin = 1'b0;
      repeat (BIT_CYC / 4) @(negedge sys_clk);
      idle(3 * BIT_CYC);
      wait_cyc(1);
      chk("false_start_ferr", 32'(ferr_cnt - fb), 32'd0);
      chk("false_start_count", 32'(fifo_count), 32'd0);
      chk("false_start_pops", 32'(got_q.size() - base), 32'd0);

      // Bad stop bit on 0x55, then 0xA3 recovers
      ready_mode = 0;
      fb = ferr_cnt;
      send_byte(8'h55, 1'b0);
      idle(2 * BIT_CYC);
      wait_cyc(1);
      chk("ferr55_pulses", 32'(ferr_cnt - fb), 32'd1);
      chk("ferr55_count", 32'(fifo_count), 32'd0);
      ready_mode = 1;
      base = got_q.size();
      send_byte(8'hA3, 1'b1);
      idle(BIT_CYC);
      wait_cyc(1);
      chk("a3_pops", 32'(got_q.size() - base), 32'd1);
      if (got_q.size() > base) chk("a3_data", 32'(got_q[base]), 32'hA3);
      chk("a3_ferr", 32'(ferr_cnt - fb), 32'd1);

      // Fill to the brim and one beyond
      ready_mode = 0;
      ob = ovf_cnt;
      fb = ferr_cnt;
      for (int i = 0; i <= FIFO_DEPTH; i++) send_byte(8'(i), 1'b1);
      idle(BIT_CYC);
      wait_cyc(1);
      chk("full_count", 32'(fifo_count), 32'(FIFO_DEPTH));
      chk("full_ovf", 32'(ovf_cnt - ob), 32'd1);
      chk("full_ferr", 32'(ferr_cnt - fb), 32'd0);
      chk("full_head", 32'(rx_data), 32'h00);
      base = got_q.size();
      ready_mode = 1;
      wait_cyc(FIFO_DEPTH + 10);
      chk("drain_count", 32'(fifo_count), 32'd0);
      chk("drain_pops", 32'(got_q.size() - base), 32'(FIFO_DEPTH));
      for (int i = 0; i < FIFO_DEPTH; i++)
         if (base + i < got_q.size()) chk($sformatf("drain_%0d", i), 32'(got_q[base + i]), 32'(i));

      // Reset in the middle of a frame
      ready_mode = 0;
      send_byte(8'h11, 1'b1);
      idle(BIT_CYC);
      wait_cyc(1);
      chk("pre_rst_count", 32'(fifo_count), 32'd1);
      b = 8'h7E;
      rx_pin = 1'b0;
      repeat (BIT_CYC) @(negedge sys_clk);
      for (int i = 0; i < 4; i++) begin
         rx_pin = b[i];
         repeat ((i == 3) ? HALF : BIT_CYC) @(negedge sys_clk);
      end
      @(posedge sys_clk);
      #1 rst_n = 1'b0;
      rx_pin = 1'b1;
      wait_cyc(3);
      chk_cleared("midrst");
      @(posedge sys_clk);
      #1 rst_n = 1'b1;
      idle(BIT_CYC);
      ready_mode = 1;
      base = got_q.size();
      send_byte(8'h7E, 1'b1);
      idle(BIT_CYC);
      wait_cyc(1);
      chk("post_rst_pops", 32'(got_q.size() - base), 32'd1);
      if (got_q.size() > base) chk("post_rst_data", 32'(got_q[base]), 32'h7E);

      // Back-to-back text line with no idle gap
      msg = "FPGA STLINV";
      exp_q.delete();
      for (int i = 0; i < msg.len(); i++) exp_q.push_back(msg[i]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      base = got_q.size();
      fb = ferr_cnt;
      ob = ovf_cnt;
      foreach (exp_q[i]) send_byte(exp_q[i], 1'b1);
      idle(BIT_CYC);
      wait_cyc(1);
      chk("str_pops", 32'(got_q.size() - base), 32'd13);
      foreach (exp_q[i])
         if (base + i < got_q.size()) chk($sformatf("str_%0d", i), 32'(got_q[base + i]), 32'(exp_q[i]));
      chk("str_ferr", 32'(ferr_cnt - fb), 32'd0);
      chk("str_ovf", 32'(ovf_cnt - ob), 32'd0);

      // Random bytes, random gaps, occasional bad stop, random consumer
      ready_mode = 2;
      exp_q.delete();
      base = got_q.size();
      fb = ferr_cnt;
      ob = ovf_cnt;
      nbad = 0;
      for (int n = 0; n < 40; n++) begin
         b   = 8'($urandom);
         bad = ($urandom_range(0, 7) == 0);
         send_byte(b, !bad);
         if (bad) begin
            nbad++;
            gap = $urandom_range(6, 30);
         end else begin
            exp_q.push_back(b);
            gap = $urandom_range(0, 30);
         end
         idle(gap);
      end
      idle(BIT_CYC);
      ready_mode = 1;
      wait_cyc(FIFO_DEPTH + 10);
      chk("rand_pops", 32'(got_q.size() - base), 32'(exp_q.size()));
      foreach (exp_q[i])
         if (base + i < got_q.size()) chk($sformatf("rand_%0d", i), 32'(got_q[base + i]), 32'(exp_q[i]));
      chk("rand_ferr", 32'(ferr_cnt - fb), 32'(nbad));
      chk("rand_ovf", 32'(ovf_cnt - ob), 32'd0);
      chk("rand_count", 32'(fifo_count), 32'd0);

      // Whole-run invariants
      chk("ferr_and_ovf_together", 32'(both_cnt), 32'd0);
      chk("valid_vs_count", 32'(inv_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
